// File: rtl/simple_risc_pkg.sv
// simple_risc_pkg: shared SimpleRISC widths, nop encoding and fetch-entry type.
// INSTR_W / PC_W : instruction and program-counter widths.
// NOP_INSTR      : SimpleRISC nop (opcode 5'b01101), shown when the queue is empty.
// fetch_entry_t  : {pc, instr} pair carried from instruction fetch to operand fetch.
package simple_risc_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h6800_0000;
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/if_of_prefetch_queue_if.sv
// if_of_prefetch_queue_if: handshake bundle between fetch, the prefetch queue and operand fetch.
// flush                         : discard all queued entries (branch taken in EX).
// in_valid/in_ready/in_instr/in_pc     : fetch-side push handshake.
// out_valid/out_ready/out_instr/out_pc : operand-fetch-side pop handshake.
// occupancy                     : current entry count, 0..DEPTH.
// Modports: slave = the queue, master = the fetch/operand-fetch environment.
interface if_of_prefetch_queue_if
    import simple_risc_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_W-1:0]     in_instr;
    logic [PC_W-1:0]        in_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_W-1:0]     out_instr;
    logic [PC_W-1:0]        out_pc;
    logic [$clog2(DEPTH):0] occupancy;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, occupancy
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, occupancy
    );
endinterface

// File: rtl/prefetch_queue_mem.sv
// prefetch_queue_mem: DEPTH x fetch_entry_t storage, one synchronous write port, one asynchronous read port.
// Clk   : write clock (rising edge).
// we    : write enable; waddr/wdata : write address and entry.
// raddr : read address; rdata : entry at raddr, combinational.
module prefetch_queue_mem
    import simple_risc_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         Clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);
    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/if_of_prefetch_queue.sv
// if_of_prefetch_queue: IF->OF instruction prefetch FIFO of {pc, instr} with flush on taken branch.
// Clk   : single clock, rising edge.
// reset : synchronous, active-low; overrides flush, push and pop.
// q     : if_of_prefetch_queue_if.slave (flush, in_* push side, out_* pop side, occupancy).
// Optional PREFETCH_BYPASS_EN: when empty, an incoming entry is presented on out_* in the
// same cycle; if consumed it is never written and never counted in occupancy.
module if_of_prefetch_queue
    import simple_risc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 reset,
    if_of_prefetch_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occupancy_q, occupancy_d;
    logic          empty, full, bypass, push, pop, wr_en, mem_pop;
    fetch_entry_t  head, in_entry;

    assign in_entry = '{pc: q.in_pc, instr: q.in_instr};

    prefetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .Clk   (Clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (in_entry),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign empty = occupancy_q == '0;
    assign full  = occupancy_q == OW'(DEPTH);
`ifdef PREFETCH_BYPASS_EN
    assign bypass = empty & q.in_valid & ~q.flush & reset;
`else
    assign bypass = 1'b0;
`endif

    // in_ready deliberately ignores out_ready: no combinational ready path through the queue.
    assign q.in_ready  = ~full & reset;
    assign q.out_valid = ~empty | bypass;
    assign q.out_instr = bypass ? q.in_instr : (empty ? NOP_INSTR : head.instr);
    assign q.out_pc    = bypass ? q.in_pc : (empty ? '0 : head.pc);
    assign q.occupancy = occupancy_q;

    always_comb begin
        push        = q.in_valid & q.in_ready;
        pop         = q.out_valid & q.out_ready;
        // A bypassed entry consumed this cycle is never stored; flush drops the input.
        wr_en       = push & ~q.flush & ~(bypass & q.out_ready);
        // Only entries actually held in storage advance the read pointer.
        mem_pop     = pop & ~empty;
        wr_ptr_d    = q.flush ? '0 : wr_ptr_q + AW'(wr_en);
        rd_ptr_d    = q.flush ? '0 : rd_ptr_q + AW'(mem_pop);
        occupancy_d = q.flush ? '0 : occupancy_q + OW'(wr_en) - OW'(mem_pop);
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occupancy_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occupancy_q <= occupancy_d;
        end
    end
endmodule

// File: tb/tb_if_of_prefetch_queue.sv
// tb_if_of_prefetch_queue: scoreboard bench; a driver predicts queue contents, a negedge monitor compares.
module tb_if_of_prefetch_queue;
    import simple_risc_pkg::*;
    localparam int DEPTH = 4;

    logic Clk = 1'b0;
    logic reset;
    always #5 Clk = ~Clk;

    if_of_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    if_of_prefetch_queue #(.DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .reset (reset),
        .q     (bus)
    );

    fetch_entry_t sb[$];
    fetch_entry_t pend_e, exp_e;
    logic         pend_v = 1'b0;
    logic         mon_en = 1'b0;
    logic         byp, exp_v;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: commit last cycle's predicted effect, then drive new inputs.
    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [31:0] pc, input logic [31:0] ins, input logic o);
        @(posedge Clk);
        if (!reset || bus.flush) sb.delete();
        else if (pend_v) sb.push_back(pend_e);
        pend_v = 1'b0;
        #1;
        reset        = r;
        bus.flush    = f;
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_instr = ins;
        bus.out_ready = o;
        pend_v = r && v && !f && sb.size() < DEPTH;
        pend_e = '{pc: pc, instr: ins};
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            byp = 1'b0;
`ifdef PREFETCH_BYPASS_EN
            byp = reset && sb.size() == 0 && bus.in_valid && !bus.flush;
`endif
            exp_v = sb.size() != 0 || byp;
            chk("in_ready", 64'(bus.in_ready), 64'(reset && sb.size() < DEPTH));
            chk("occupancy", 64'(bus.occupancy), 64'(sb.size()));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
            if (exp_v) begin
                exp_e = byp ? '{pc: bus.in_pc, instr: bus.in_instr} : sb[0];
                chk("out_pc", 64'(bus.out_pc), 64'(exp_e.pc));
                chk("out_instr", 64'(bus.out_instr), 64'(exp_e.instr));
                if (bus.out_ready) begin
                    if (byp) pend_v = 1'b0;
                    else void'(sb.pop_front());
                end
            end else begin
                chk("idle_pc", 64'(bus.out_pc), 64'd0);
                chk("idle_instr", 64'(bus.out_instr), 64'(NOP_INSTR));
            end
        end
    end

    initial begin
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pc = '0;
        bus.in_instr = '0;
        bus.out_ready = 1'b0;
        @(posedge Clk);
        mon_en = 1'b1;
        // reset held with in_valid high, then release
        repeat (3) drive(1'b0, 1'b0, 1'b1, 32'h100, 32'h55, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        // fill to full, fifth push refused, then drain in order
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 32'(4 * i), 32'(i + 1), 1'b0);
        repeat (6) drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        // hold occupancy 2 across pointer wrap
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, 32'(32'h200 + 4 * i), 32'(32'hA0 + i), 1'b0);
        for (int i = 2; i < 12; i++) drive(1'b1, 1'b0, 1'b1, 32'(32'h200 + 4 * i), 32'(32'hA0 + i), 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        // flush beats push and pop in the same cycle
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 32'(32'h300 + 4 * i), 32'(i), 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h3F0, 32'hDEAD, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        // full plus pop: pop only, next cycle push accepted
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 32'(32'h400 + 4 * i), 32'(i), 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h410, 32'h77, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 32'h414, 32'h78, 1'b0);
        repeat (6) drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        // empty queue, single entry pc 0x40
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h99, 1'b1);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
                  $urandom, $urandom, $urandom_range(0, 9) < 5);
        repeat (6) drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        @(posedge Clk);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
